// File: rtl/leiwand_rv32_wb_arbiter.sv
// leiwand_rv32_wb_arbiter
// Two-master, two-slave Wishbone arbiter and address decoder.
// m0 (core) and m1 (secondary master) compete for one shared slave bus.
// A grant is held for as long as the owning master keeps cyc asserted.
// Ties out of IDLE go to the master that did not hold the bus last.
// Strobes that hit neither slave window are answered one cycle later
// with ack+err, so a master never hangs on an unmapped address.
//
// Ports
//   clk, reset                         clock, synchronous active-high reset
//   mN_cyc/stb/we/addr/data_out        master request (N = 0, 1)
//   mN_data_in/ack/stall/err           response to master N
//   s_cyc/we/addr/data_out             shared slave request
//   s0_stb, s1_stb                     decoded per-slave strobes
//   sN_ack/stall/data_in               slave responses (slaves drive 0 when idle)
//
// state | meaning
// IDLE  | no master granted, slave bus quiet
// GNT0  | m0 owns the slave bus
// GNT1  | m1 owns the slave bus
module leiwand_rv32_wb_arbiter #(
    parameter int                   MEM_WIDTH = 32,
    parameter logic [MEM_WIDTH-1:0] S0_BASE   = 32'h1000_0000,
    parameter int                   S0_WORDS  = 128,
    parameter logic [MEM_WIDTH-1:0] S1_BASE   = 32'h2000_0000,
    parameter int                   S1_WORDS  = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m0_cyc,
    input  logic                 m0_stb,
    input  logic                 m0_we,
    input  logic [MEM_WIDTH-1:0] m0_addr,
    input  logic [MEM_WIDTH-1:0] m0_data_out,
    output logic [MEM_WIDTH-1:0] m0_data_in,
    output logic                 m0_ack,
    output logic                 m0_stall,
    output logic                 m0_err,
    input  logic                 m1_cyc,
    input  logic                 m1_stb,
    input  logic                 m1_we,
    input  logic [MEM_WIDTH-1:0] m1_addr,
    input  logic [MEM_WIDTH-1:0] m1_data_out,
    output logic [MEM_WIDTH-1:0] m1_data_in,
    output logic                 m1_ack,
    output logic                 m1_stall,
    output logic                 m1_err,
    output logic                 s_cyc,
    output logic                 s_we,
    output logic [MEM_WIDTH-1:0] s_addr,
    output logic [MEM_WIDTH-1:0] s_data_out,
    output logic                 s0_stb,
    output logic                 s1_stb,
    input  logic                 s0_ack,
    input  logic                 s0_stall,
    input  logic [MEM_WIDTH-1:0] s0_data_in,
    input  logic                 s1_ack,
    input  logic                 s1_stall,
    input  logic [MEM_WIDTH-1:0] s1_data_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Window ends are computed one bit wider so a window touching the top
    // of the address space does not wrap.
    localparam logic [MEM_WIDTH:0] S0_END = {1'b0, S0_BASE} + (MEM_WIDTH+1)'(4 * S0_WORDS);
    localparam logic [MEM_WIDTH:0] S1_END = {1'b0, S1_BASE} + (MEM_WIDTH+1)'(4 * S1_WORDS);

    state_t               state, state_next;
    logic                 last_grant, last_grant_next;
    logic                 err_ack, err_ack_next;

    logic                 g_cyc, g_stb, g_we;
    logic [MEM_WIDTH-1:0] g_addr, g_data;
    logic                 hit0, hit1;
    logic                 resp_ack, resp_stall;
    logic [MEM_WIDTH-1:0] resp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            err_ack    <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            err_ack    <= err_ack_next;
        end
    end

    // Request of the granted master; everything reads as zero in IDLE.
    always_comb begin
        g_cyc  = 1'b0;
        g_stb  = 1'b0;
        g_we   = 1'b0;
        g_addr = '0;
        g_data = '0;
        case (state)
            GNT0: begin
                g_cyc  = m0_cyc;
                g_stb  = m0_stb;
                g_we   = m0_we;
                g_addr = m0_addr;
                g_data = m0_data_out;
            end
            GNT1: begin
                g_cyc  = m1_cyc;
                g_stb  = m1_stb;
                g_we   = m1_we;
                g_addr = m1_addr;
                g_data = m1_data_out;
            end
            default: ;
        endcase
    end

    assign hit0 = ({1'b0, g_addr} >= {1'b0, S0_BASE}) && ({1'b0, g_addr} < S0_END);
    assign hit1 = ({1'b0, g_addr} >= {1'b0, S1_BASE}) && ({1'b0, g_addr} < S1_END);

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        err_ack_next    = 1'b0;
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    state_next = last_grant ? GNT0 : GNT1;
                end else if (m0_cyc) begin
                    state_next = GNT0;
                end else if (m1_cyc) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (m0_cyc) begin
                    err_ack_next = g_stb && !hit0 && !hit1;
                end else begin
                    last_grant_next = 1'b0;
                    state_next      = m1_cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (m1_cyc) begin
                    err_ack_next = g_stb && !hit0 && !hit1;
                end else begin
                    last_grant_next = 1'b1;
                    state_next      = m0_cyc ? GNT0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign s_cyc      = g_cyc;
    assign s_we       = g_we;
    assign s_addr     = g_addr;
    assign s_data_out = g_data;
    assign s0_stb     = g_stb && hit0;
    assign s1_stb     = g_stb && hit1 && !hit0;

    // Responses are simply ORed; idle slaves drive zero, and an unmapped
    // strobe contributes only the registered err_ack.
    assign resp_ack   = s0_ack | s1_ack | err_ack;
    assign resp_stall = s0_stall | s1_stall;
    assign resp_data  = s0_data_in | s1_data_in;

    always_comb begin
        m0_data_in = '0;
        m0_ack     = 1'b0;
        m0_stall   = 1'b1;
        m0_err     = 1'b0;
        m1_data_in = '0;
        m1_ack     = 1'b0;
        m1_stall   = 1'b1;
        m1_err     = 1'b0;
        case (state)
            GNT0: begin
                m0_data_in = resp_data;
                m0_ack     = resp_ack;
                m0_stall   = resp_stall;
                m0_err     = err_ack;
            end
            GNT1: begin
                m1_data_in = resp_data;
                m1_ack     = resp_ack;
                m1_stall   = resp_stall;
                m1_err     = err_ack;
            end
            default: ;
        endcase
    end

endmodule
